// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed D priority with starvation guard.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, next_state;
  logic [TW-1:0] tmo_cnt;
  logic          cur_store;
  logic          grant_if, grant_d;
  logic          done, tmo, finish;
  logic [31:0]   resp_data;

`ifdef MEM_ARB_RR_EN
  logic prio_if;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      prio_if <= 1'b0;
    else if (grant_if || grant_d)
      prio_if <= ~prio_if;
  end

  assign grant_if = (state == IDLE) && if_req && (!d_req || prio_if);
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  // Counts D wins that a waiting fetch lost; reaching STARVE_MAX hands the next slot to IF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (!if_req || grant_if)
      starve_cnt <= '0;
    else if (grant_d)
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign grant_if = (state == IDLE) && if_req && (!d_req || starve_cnt == SW'(STARVE_MAX));
`endif

  assign grant_d = (state == IDLE) && d_req && !grant_if;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // A completion arriving on the timeout cycle takes precedence over the abort.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    tmo        = 1'b0;
    resp_data  = 32'h0;
    case (state)
      IDLE: begin
        if (grant_if)
          next_state = BUSY_IF;
        else if (grant_d)
          next_state = BUSY_D;
      end
      BUSY_IF, BUSY_D: begin
        done = mem_rvalid;
        tmo  = !mem_rvalid && (tmo_cnt == TW'(TIMEOUT));
        if (done || tmo)
          next_state = IDLE;
        if (tmo)
          resp_data = 32'hDEADBEEF;
        else if (!(state == BUSY_D && cur_store))
          resp_data = mem_rdata;
      end
      default: next_state = IDLE;
    endcase
  end

  assign finish = done || tmo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      cur_store <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
      err       <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if_gnt    <= grant_if;
      d_gnt     <= grant_d;
      mem_req   <= grant_if || grant_d;
      mem_wen   <= grant_d && d_wen;
      mem_addr  <= grant_if ? if_addr : (grant_d ? d_addr : 32'h0);
      mem_wdata <= (grant_d && d_wen) ? d_wdata : 32'h0;
      mem_wstrb <= (grant_d && d_wen) ? d_wstrb : 4'h0;
      if (grant_d)
        cur_store <= d_wen;
      if_rvalid <= (state == BUSY_IF) && finish;
      d_rvalid  <= (state == BUSY_D) && finish;
      if_rdata  <= ((state == BUSY_IF) && finish) ? resp_data : 32'h0;
      d_rdata   <= ((state == BUSY_D) && finish) ? resp_data : 32'h0;
      err       <= tmo;
      tmo_cnt   <= (state != IDLE && next_state != IDLE) ? tmo_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses, a monitor checks them.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_wen, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        err, mem_req, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit          side_if;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gnt_cyc;
  } gnt_exp_t;

  typedef struct {
    bit          side_if;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } resp_exp_t;

  gnt_exp_t  gnt_q[$];
  resp_exp_t resp_q[$];
  gnt_exp_t  g_mon;
  resp_exp_t r_mon;
  int        last_gnt_cyc = 0;

  // Memory model: answers each mem_req after mem_lat cycles (never when negative).
  int          mem_lat = -1;
  logic [31:0] mem_data = 32'h0;
  logic        resp_rvalid = 1'b0;
  logic        inj_rvalid = 1'b0;

  assign mem_rvalid = resp_rvalid | inj_rvalid;
  assign mem_rdata  = resp_rvalid ? mem_data : 32'h0BAD0BAD;

  always begin
    @(negedge clk);
    if (mem_req && mem_lat >= 0) begin
      repeat (mem_lat) @(negedge clk);
      resp_rvalid = 1'b1;
      @(negedge clk);
      resp_rvalid = 1'b0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ctrl"}, {if_gnt, d_gnt, if_rvalid, d_rvalid, err, mem_req, mem_wen}, 32'h0);
    check_output({tag, "_mem_addr"}, mem_addr, 32'h0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check_output({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    check_output({tag, "_rdata"}, if_rdata | d_rdata, 32'h0);
  endtask

  // Monitor: every grant and every response must match the head of its queue.
  always @(negedge clk) begin
    if (if_gnt || d_gnt || mem_req) begin
      if (gnt_q.size() == 0) begin
        check_output("unexpected_gnt", {if_gnt, d_gnt, mem_req}, 32'h0);
      end else begin
        g_mon = gnt_q.pop_front();
        check_output("gnt_side", {if_gnt, d_gnt}, g_mon.side_if ? 32'h2 : 32'h1);
        check_output("mem_req", mem_req, 32'h1);
        check_output("mem_wen", mem_wen, g_mon.wen);
        check_output("mem_addr", mem_addr, g_mon.addr);
        check_output("mem_wstrb", mem_wstrb, g_mon.wstrb);
        if (g_mon.wen)
          check_output("mem_wdata", mem_wdata, g_mon.wdata);
        if (g_mon.gnt_cyc >= 0)
          check_output("gnt_cycle", cyc, g_mon.gnt_cyc);
        last_gnt_cyc = cyc;
      end
    end
    if (if_rvalid || d_rvalid || err) begin
      if (resp_q.size() == 0) begin
        check_output("unexpected_rvalid", {if_rvalid, d_rvalid, err}, 32'h0);
      end else begin
        r_mon = resp_q.pop_front();
        check_output("rvalid_side", {if_rvalid, d_rvalid}, r_mon.side_if ? 32'h2 : 32'h1);
        check_output("rdata", r_mon.side_if ? if_rdata : d_rdata, r_mon.rdata);
        check_output("err", err, r_mon.err);
        check_output("rvalid_latency", cyc - last_gnt_cyc, r_mon.lat);
      end
    end
  end

  // Issues one request (called at a negedge) and waits for its grant and response.
  task automatic apply_stimulus(input bit side_if, input bit wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int lat, input logic [31:0] rdata);
    gnt_exp_t  g;
    resp_exp_t r;
    bit        tmo;
    bit        seen;
    tmo      = (lat < 0) || (lat > TIMEOUT);
    mem_lat  = lat;
    mem_data = rdata;
    g = '{side_if, wen, addr, wdata, (!side_if && wen) ? wstrb : 4'h0, cyc + 1};
    r = '{side_if, tmo ? 32'hDEADBEEF : (wen ? 32'h0 : rdata), tmo, tmo ? TIMEOUT + 1 : lat + 1};
    gnt_q.push_back(g);
    resp_q.push_back(r);
    if (side_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_wen   = wen;
      d_addr  = addr;
      d_wdata = wdata;
      d_wstrb = wstrb;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = if_gnt | d_gnt;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check_output("gnt_wait", seen, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = if_rvalid | d_rvalid;
    end
    check_output("rvalid_wait", seen, 32'h1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    bit  want_if;
    reset   = 1'b0;
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_wen   = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single load, store, fetch");
    apply_stimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 2, 32'hCAFEF00D);
    apply_stimulus(1'b0, 1'b1, 32'h104, 32'h11223344, 4'b0001, 1, 32'h99999999);
    apply_stimulus(1'b1, 1'b0, 32'h1003, 32'h0, 4'h0, 1, 32'h00000013);

    $display("[TB] timeout and completion on the timeout cycle");
    apply_stimulus(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, -1, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h2004, 32'h0, 4'h0, TIMEOUT, 32'hFEEDFACE);

    $display("[TB] contention");
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_lat  = 1;
    mem_data = 32'h5A5A0001;
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
      want_if = (i % 2) == 1;
`else
      want_if = (i % 5) == 4;
`endif
      gnt_q.push_back('{want_if, 1'b0, want_if ? 32'h200 : 32'h300, 32'h0, 4'h0, -1});
      resp_q.push_back('{want_if, 32'h5A5A0001, 1'b0, 2});
    end
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b1;
    d_wen   = 1'b0;
    d_addr  = 32'h300;
    d_wstrb = 4'h0;
    n = 0;
    for (int i = 0; i < 300 && n < 10; i++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) n++;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check_output("contention_grants", n, 32'd10);
    for (int i = 0; i < 20 && resp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);

    $display("[TB] reset during a data transaction");
    mem_lat = -1;
    gnt_q.push_back('{1'b0, 1'b0, 32'h400, 32'h0, 4'h0, cyc + 1});
    d_req  = 1'b1;
    d_wen  = 1'b0;
    d_addr = 32'h400;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = d_gnt;
    end
    d_req = 1'b0;
    check_output("t5_gnt_wait", seen, 32'h1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    inj_rvalid = 1'b1;
    @(negedge clk);
    inj_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h404, 32'h0, 4'h0, 1, 32'h600DCAFE);

    repeat (3) @(negedge clk);
    check_output("gnt_q_empty", gnt_q.size(), 32'h0);
    check_output("resp_q_empty", resp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
